// File: rtl/instr_fetch.sv
// instr_fetch: PC, branch redirect and a single registered output stage with valid/ready handshake.
module instr_fetch #(
    parameter int          profundidad = 1024,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                               CLK,
    input  logic                               RESET,
    output logic [$clog2(profundidad-1)-1:0]   rom_addr,
    input  logic [31:0]                        rom_data,
    output logic [31:0]                        instr,
    output logic [31:0]                        pc_out,
    output logic                               instr_valid,
    input  logic                               instr_ready,
    input  logic                               branch_taken,
    input  logic [31:0]                        branch_target,
    input  logic                               halt,
    output logic [31:0]                        fetch_count
);
    localparam int AW = $clog2(profundidad - 1);
    logic [31:0] pc_q, pc_d, instr_q, instr_d, pc_out_q, pc_out_d, cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [31:0] fa;
    logic        hs, slot_free, load;
    always_comb begin
        fa        = branch_taken ? {branch_target[31:2], 2'b00} : pc_q;
        rom_addr  = fa[AW+1:2];
        hs        = valid_q & instr_ready;
        slot_free = !valid_q | instr_ready;
        load      = !halt & (slot_free | branch_taken);
        cnt_d     = cnt_q + {31'd0, hs};
        instr_d   = load ? rom_data : instr_q;
        pc_out_d  = load ? fa : pc_out_q;
        // a redirect under halt only retargets pc and drops the pending word
        pc_d      = load ? fa + 32'd4 : (branch_taken ? fa : pc_q);
        valid_d   = load | (valid_q & !hs & !branch_taken);
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign fetch_count = cnt_q;
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit that drives the instruction ROM (combinational read, 32-bit words, word-addressed, `profundidad` entries) and delivers instructions to the decode stage. It holds the program counter, handles taken-branch and jump redirects from execute, and registers each fetched instruction into a single output stage with a valid/ready handshake. It also counts delivered instructions. It sits between the ROM and the core's decode stage.

## Interface
- `profundidad`, 1024, ROM depth in 32-bit words; must match the ROM instance.
- `RESET_PC`, 32'h0000_0000, byte address of the first instruction after reset.
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  reset, synchronous, active-high.
- rom_addr  out  $clog2(profundidad-1)  word address to the ROM; combinational.
- rom_data  in  32  ROM word at rom_addr, valid in the same cycle.
- instr  out  32  registered instruction.
- pc_out  out  32  byte address of `instr`.
- instr_valid  out  1  `instr` and `pc_out` hold an undelivered instruction.
- instr_ready  in  1  decode accepts in this cycle.
- branch_taken  in  1  one-cycle redirect request.
- branch_target  in  32  redirect byte address; sampled only when branch_taken=1.
- halt  in  1  freeze fetching while high.
- fetch_count  out  32  number of handshakes (instr_valid & instr_ready) since reset.

## Operation
- State: `pc` (32 b, address of the next word to fetch), output register {instr, pc_out, instr_valid}, and `fetch_count`.
- Alignment: branch_target[1:0] is ignored and treated as 00. pc increments by 4 with 32-bit wrap.
- ROM address: `fa` = branch_taken ? {branch_target[31:2],2'b00} : pc. rom_addr = fa[AW+1:2], where AW = width of rom_addr. Upper bits are dropped, so addresses past the ROM wrap modulo the ROM size.
- Handshake: `hs` = instr_valid & instr_ready. `slot_free` = !instr_valid | instr_ready.
- Load condition: `load` = !halt & (slot_free | branch_taken). On load, instr<=rom_data, pc_out<=fa, instr_valid<=1, pc<=fa+4.
- Redirect with halt=1: pc<=target and instr_valid<=0. Nothing is loaded. The target is fetched on the first cycle with halt=0.
- No load and no redirect:
  - hs=1: instr_valid<=0.
  - Otherwise the output register holds its value.
  - pc holds in both cases.
- Redirect always discards an undelivered instruction. If hs=1 in the same cycle, that instruction counts as delivered.
- fetch_count increments by 1 on every hs cycle, including a cycle with a redirect. It wraps at 2^32.
- While instr_valid=1 and instr_ready=0, instr and pc_out are stable.

## Timing
- Reset (RESET=1 at an edge): pc<=RESET_PC, instr_valid<=0, instr<=0, pc_out<=0, fetch_count<=0. During reset, rom_addr reflects pc or branch_target combinationally; nothing is loaded.
- First edge after RESET falls, with halt=0: the instruction at RESET_PC is loaded and instr_valid=1 in the next cycle.
- Fetch latency: 1 cycle from rom_addr presentation to instr_valid.
- Throughput: 1 instruction/cycle while instr_ready=1 and halt=0.
- Redirect latency: target instruction is valid on the cycle after branch_taken (zero bubbles), if halt=0.
- RESET asserted mid-stream overrides branch_taken, halt and hs. A pending instruction is dropped and not counted.
- halt does not clear instr_valid. An already valid instruction can still be handshaked while halt=1; after that, instr_valid=0 until halt falls.

## Test plan
- ROM model word i = 32'hA000_0000+i; reset 3 cycles, then instr_ready=1 → instr = A0000000, A0000001, … on consecutive cycles; pc_out = 0, 4, 8, …; fetch_count = 5 after 5 valid cycles.
- Backpressure: hold instr_ready=0 for 4 cycles at pc_out=8 → instr stays A0000002, rom_addr stays 3, fetch_count unchanged; release → A0000003 follows immediately.
- Redirect: branch_taken=1, branch_target=32'h0000_0042 while instr_valid=1, instr_ready=0 → next cycle instr=A0000010, pc_out=0x40; the discarded instruction is not counted.
- Redirect coincident with a handshake → fetch_count +1, next instr is the target word. Target 32'h0000_1004 with profundidad=1024 → rom_addr=1 (wrap), pc_out=0x1004.
- Halt: halt=1 with instr_valid=1 and instr_ready=1 → one handshake, then instr_valid=0 and pc frozen. Branch_taken during halt → target is fetched the cycle after halt falls.
- Reset mid-stream at pc_out=0x20 with instr_valid=1 → next cycle instr_valid=0, fetch_count=0, and after release the first instr is the RESET_PC word.
